music_seq_player: RTL and testbench
===================================

Name: music_seq_player

Overview:
- Song sequencer FSM. On a start command it walks a song stored in word-addressed memory, one 32-bit word per note.
- Each word selects one of seven tone generators, or silence. That selection is held for a programmable duration, then the next word is fetched.
- An end-of-song marker returns the block to idle.
- Sits between the song memory and the audio output pin.

Parameters:
- none (all widths fixed below)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- song_sel  in  5  song number; song base address = song_sel << 9 (512 bytes per song)
- start_song  in  1  start request, sampled only in IDLE
- state  out  2  current FSM state (RESET=0, IDLE=1, SET_NOTE=2, WAIT_NOTE=3)
- idle  out  1  high only in IDLE
- note_duration  in  16  duration count, sampled in SET_NOTE
- note1_period..note7_period  in  8 each  half-period setting of tone generators 1..7
- note_sel  out  3  active note; 0 outside WAIT_NOTE
- note  out  1  tone output; 0 when note_sel=0
- memreq_val  out  1  memory read request, combinational
- memreq_addr  out  16  byte address of the current note word
- memresp_data  in  32  read data, valid combinationally in the same cycle as the request

Behaviour:
- Reset (rst_n=0, async): state forced to RESET immediately.
  - Cleared on reset: note index, duration counter, latched note, all tone generators.
  - Outputs during reset: idle=0, note_sel=0, note=0, memreq_val=0.
- RESET: lasts exactly one cycle after rst_n deasserts, then goes to IDLE. start_song is ignored here.
- IDLE: idle=1.
  - If start_song=1 at the clock edge: next state is SET_NOTE and the note index clears to 0.
  - Otherwise stay in IDLE.
- SET_NOTE (one cycle):
  - memreq_val=1; memreq_addr = {song_sel, index[6:0], 2'b00}.
  - If memresp_data == 0xFFFF_FFFF (end of song): next state is IDLE.
  - Otherwise:
    - latch note = memresp_data[2:0]
    - load duration counter = note_duration
    - increment index (7-bit, wraps within the song region)
    - next state is WAIT_NOTE
  - note_sel=0 and note=0 during SET_NOTE.
- WAIT_NOTE:
  - note_sel = latched note; note = output of the selected tone generator.
  - If counter==0: next state is SET_NOTE. Otherwise decrement the counter.
  - Total WAIT_NOTE length is note_duration+1 cycles; note_duration=0 gives 1 cycle.
  - A latched note of 0 plays silence for the full duration.
- memreq_val=0 and memreq_addr=0 in every state except SET_NOTE.
- Tone generator k (k=1..7): free-running from reset, independent of FSM state.
  - 8-bit counter; output starts at 0.
  - Each cycle: if counter == period_k, counter←0 and output toggles; else counter increments.
  - The output mux selects generator note_sel combinationally.
- Reset mid-song: aborts immediately. Sequence is RESET (1 cycle), then IDLE; a new start replays from index 0.
- song_sel and note_duration may change at any time; only their values in SET_NOTE matter.

Decomposition:
- Shared package: state encoding constants, END_OF_SONG = 32'hFFFF_FFFF, SONG_SHIFT = 9.
- Sub-module multi_note_player: seven tone generators plus the 8:1 output mux (input 0 = constant 0).

Test Plan:
- Basic song (song 0): mem[0x0]=3, mem[0x4]=1, duration=4.
  - Reset, then 1 RESET cycle, then IDLE; assert start_song.
  - SET_NOTE reads addr 0x0, note_sel=0.
  - 5 cycles with note_sel=3, note = generator-3 output.
  - SET_NOTE reads 0x4, then 5 cycles with note_sel=1.
- End of song: mem[0x4]=0xFFFF_FFFF.
  - After the first note, SET_NOTE reads 0x4, then IDLE with idle=1 and note_sel=0, held.
- Reset in IDLE: rst_n low while idle.
  - idle drops at once; start_song during RESET is ignored; one RESET cycle, then IDLE.
- Reset mid-note: mem[0x0]=4, duration=6.
  - Reset after 4 WAIT cycles returns to RESET, then IDLE.
  - Restart with duration=3: address 0x0 again, 4 cycles with note_sel=4.
  - Next word 0 gives 4 silent cycles (note_sel=0, note=0).
- Song offset: song_sel=3, mem[0x600]=5, mem[0x604]=7, durations 7 then 2.
  - Addresses 0x600 and 0x604.
  - 8 cycles with note_sel=5, then 3 cycles with note_sel=7.
- Tone generators: with periods 1..7, generator k toggles every k+1 cycles from reset; check note against this for each note_sel.

Source files
------------

// File: rtl/music_seq_player_pkg.sv
// Shared widths, state encoding and song-format constants for the song sequencer.
package music_seq_player_pkg;

  localparam int unsigned NUM_TONES  = 7;
  localparam int unsigned PERIOD_W   = 8;
  localparam int unsigned NOTE_W     = 3;
  localparam int unsigned IDX_W      = 7;
  localparam int unsigned DUR_W      = 16;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned SONG_W     = 5;
  localparam int unsigned SONG_SHIFT = 9;

  localparam logic [DATA_W-1:0] END_OF_SONG = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_IDLE      = 2'd1,
    ST_SET_NOTE  = 2'd2,
    ST_WAIT_NOTE = 2'd3
  } state_e;

endpackage

// File: rtl/music_seq_player_multi_note_player.sv
// Seven free-running square-wave tone generators and the note-select output mux.
module multi_note_player
  import music_seq_player_pkg::*;
(
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_TONES-1:0][PERIOD_W-1:0] period,
  input  logic [NOTE_W-1:0]                  note_sel,
  output logic                               note
);

  logic [NUM_TONES-1:0][PERIOD_W-1:0] cnt_q, cnt_d;
  logic [NUM_TONES-1:0]               tone_q, tone_d;
  logic [NUM_TONES:0]                 tones;

  // Each generator toggles when its counter reaches the half-period setting.
  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    for (int unsigned k = 0; k < NUM_TONES; k++) begin
      if (cnt_q[k] == period[k]) begin
        cnt_d[k]  = '0;
        tone_d[k] = ~tone_q[k];
      end else begin
        cnt_d[k] = cnt_q[k] + PERIOD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tone_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  // Select 0 is silence.
  assign tones = {tone_q, 1'b0};
  assign note  = tones[note_sel];

endmodule

// File: rtl/music_seq_player.sv
// Song sequencer: fetches one note word per step from song memory and plays it for a set duration.
module music_seq_player
  import music_seq_player_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SONG_W-1:0]   song_sel,
  input  logic                start_song,
  output logic [1:0]          state,
  output logic                idle,
  input  logic [DUR_W-1:0]    note_duration,
  input  logic [PERIOD_W-1:0] note1_period,
  input  logic [PERIOD_W-1:0] note2_period,
  input  logic [PERIOD_W-1:0] note3_period,
  input  logic [PERIOD_W-1:0] note4_period,
  input  logic [PERIOD_W-1:0] note5_period,
  input  logic [PERIOD_W-1:0] note6_period,
  input  logic [PERIOD_W-1:0] note7_period,
  output logic [NOTE_W-1:0]   note_sel,
  output logic                note,
  output logic                memreq_val,
  output logic [ADDR_W-1:0]   memreq_addr,
  input  logic [DATA_W-1:0]   memresp_data
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DUR_W-1:0]   cnt_q, cnt_d;
  logic [NOTE_W-1:0]  note_q, note_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      idx_q   <= '0;
      cnt_q   <= '0;
      note_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      note_q  <= note_d;
    end
  end

  // Next state plus note index, duration counter and latched note.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    note_d  = note_q;
    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE: begin
        if (start_song) begin
          state_d = ST_SET_NOTE;
          idx_d   = '0;
        end
      end
      ST_SET_NOTE: begin
        if (memresp_data == END_OF_SONG) begin
          state_d = ST_IDLE;
        end else begin
          note_d  = memresp_data[NOTE_W-1:0];
          cnt_d   = note_duration;
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_WAIT_NOTE;
        end
      end
      ST_WAIT_NOTE: begin
        if (cnt_q == '0) begin
          state_d = ST_SET_NOTE;
        end else begin
          cnt_d = cnt_q - DUR_W'(1);
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  // State-decoded outputs; the memory request is only live while fetching.
  always_comb begin
    idle        = 1'b0;
    note_sel    = '0;
    memreq_val  = 1'b0;
    memreq_addr = '0;
    case (state_q)
      ST_IDLE: idle = 1'b1;
      ST_SET_NOTE: begin
        memreq_val  = 1'b1;
        memreq_addr = (ADDR_W'(song_sel) << SONG_SHIFT) | (ADDR_W'(idx_q) << 2);
      end
      ST_WAIT_NOTE: note_sel = note_q;
      default: ;
    endcase
  end

  assign state = state_q;

  multi_note_player u_player (
    .clk      (clk),
    .rst_n    (rst_n),
    .period   ({note7_period, note6_period, note5_period, note4_period,
                note3_period, note2_period, note1_period}),
    .note_sel (note_sel),
    .note     (note)
  );

endmodule

// File: tb/tb_music_seq_player.sv
// Randomized self-checking bench for music_seq_player against a song-level reference model.
module tb_music_seq_player;

  localparam logic [31:0] EOS = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic [4:0]  song_sel;
  logic        start_song;
  logic [1:0]  state;
  logic        idle;
  logic [15:0] note_duration;
  logic [7:0]  note1_period, note2_period, note3_period, note4_period;
  logic [7:0]  note5_period, note6_period, note7_period;
  logic [2:0]  note_sel;
  logic        note;
  logic        memreq_val;
  logic [15:0] memreq_addr;
  logic [31:0] memresp_data;

  logic [31:0] mem [4096];
  int          per_tab [8];
  int          edges;
  int          dur_q [$];
  int          errors;
  int          checks;

  music_seq_player dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .song_sel      (song_sel),
    .start_song    (start_song),
    .state         (state),
    .idle          (idle),
    .note_duration (note_duration),
    .note1_period  (note1_period),
    .note2_period  (note2_period),
    .note3_period  (note3_period),
    .note4_period  (note4_period),
    .note5_period  (note5_period),
    .note6_period  (note6_period),
    .note7_period  (note7_period),
    .note_sel      (note_sel),
    .note          (note),
    .memreq_val    (memreq_val),
    .memreq_addr   (memreq_addr),
    .memresp_data  (memresp_data)
  );

  assign memresp_data = mem[memreq_addr[13:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges seen since reset release: the tone generators' time base.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Generator k with half-period p flips every p+1 edges, starting low.
  function automatic logic tone_exp(input int k, input int n);
    if (k == 0) return 1'b0;
    return ((n / (per_tab[k] + 1)) % 2) == 1;
  endfunction

  // Called at a negedge; leaves the DUT idle at a negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    start_song = 1'b1;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_idle", 32'(idle), 32'd0);
    chk("rst_note_sel", 32'(note_sel), 32'd0);
    chk("rst_note", 32'(note), 32'd0);
    chk("rst_memreq_val", 32'(memreq_val), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_state", 32'(state), 32'd0);
    @(negedge clk);
    chk("post_rst_state", 32'(state), 32'd1);
    chk("post_rst_idle", 32'(idle), 32'd1);
    start_song = 1'b0;
  endtask

  // Start song from idle and follow it note by note; abort with reset if no end marker.
  task automatic run_song(input int song, input int max_notes);
    logic [31:0] word;
    logic [15:0] addr;
    int          dur;
    int          k;
    song_sel      = 5'(song);
    note_duration = 16'($urandom);
    start_song    = 1'b1;
    @(negedge clk);
    start_song = 1'b0;
    for (int i = 0; i < max_notes; i++) begin
      addr = 16'(song * 512 + (i % 128) * 4);
      word = mem[addr[13:2]];
      chk("set_state", 32'(state), 32'd2);
      chk("set_memreq_val", 32'(memreq_val), 32'd1);
      chk("set_memreq_addr", 32'(memreq_addr), 32'(addr));
      chk("set_note_sel", 32'(note_sel), 32'd0);
      chk("set_note", 32'(note), 32'd0);
      dur = (dur_q.size() > 0) ? dur_q.pop_front() : int'($urandom_range(0, 6));
      note_duration = 16'(dur);
      @(negedge clk);
      if (word == EOS) begin
        repeat (3) begin
          chk("eos_state", 32'(state), 32'd1);
          chk("eos_idle", 32'(idle), 32'd1);
          chk("eos_note_sel", 32'(note_sel), 32'd0);
          chk("eos_memreq_val", 32'(memreq_val), 32'd0);
          @(negedge clk);
        end
        return;
      end
      k = int'(word[2:0]);
      for (int c = 0; c <= dur; c++) begin
        chk("wait_state", 32'(state), 32'd3);
        chk("wait_note_sel", 32'(note_sel), 32'(k));
        chk("wait_note", 32'(note), 32'(tone_exp(k, edges)));
        chk("wait_memreq_val", 32'(memreq_val), 32'd0);
        chk("wait_memreq_addr", 32'(memreq_addr), 32'd0);
        note_duration = 16'($urandom);
        song_sel      = (c == dur) ? 5'(song) : 5'($urandom);
        @(negedge clk);
      end
    end
    do_reset();
  endtask

  initial begin
    logic [31:0] d;
    int          song;
    int          len;
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    start_song = 1'b0;
    song_sel = '0;
    note_duration = '0;
    for (int k = 0; k < 8; k++) per_tab[k] = k;
    note1_period = 8'(per_tab[1]);
    note2_period = 8'(per_tab[2]);
    note3_period = 8'(per_tab[3]);
    note4_period = 8'(per_tab[4]);
    note5_period = 8'(per_tab[5]);
    note6_period = 8'(per_tab[6]);
    note7_period = 8'(per_tab[7]);
    for (int a = 0; a < 4096; a++) mem[a] = 32'd0;

    @(negedge clk);
    do_reset();

    // Basic two-note song.
    mem[0] = 32'd3; mem[1] = 32'd1; mem[2] = EOS;
    dur_q = '{4, 4};
    run_song(0, 10);

    // End marker right after the first note.
    mem[1] = EOS;
    dur_q = '{4};
    run_song(0, 10);

    // Reset while idle.
    do_reset();

    // Reset in the middle of a note, then replay from the start.
    mem[0] = 32'd4; mem[1] = 32'd0; mem[2] = EOS;
    song_sel = 5'd0;
    note_duration = 16'd6;
    start_song = 1'b1;
    @(negedge clk);
    start_song = 1'b0;
    chk("mid_set_state", 32'(state), 32'd2);
    chk("mid_set_addr", 32'(memreq_addr), 32'd0);
    @(negedge clk);
    repeat (4) begin
      chk("mid_wait_state", 32'(state), 32'd3);
      chk("mid_wait_note_sel", 32'(note_sel), 32'd4);
      chk("mid_wait_note", 32'(note), 32'(tone_exp(4, edges)));
      @(negedge clk);
    end
    do_reset();
    dur_q = '{3, 3};
    run_song(0, 10);

    // Song at a non-zero base.
    mem[12'h180] = 32'd5; mem[12'h181] = 32'd7; mem[12'h182] = EOS;
    dur_q = '{7, 2};
    run_song(3, 10);

    // Random songs with random note words and durations.
    for (int r = 0; r < 20; r++) begin
      song = int'($urandom_range(0, 30));
      len  = int'($urandom_range(1, 8));
      for (int w = 0; w < len; w++) begin
        d = $urandom;
        if (d == EOS) d = 32'd2;
        mem[song * 128 + w] = d;
      end
      mem[song * 128 + len] = EOS;
      dur_q.delete();
      run_song(song, 20);
      if ($urandom_range(0, 4) == 0) do_reset();
    end

    // A song with no end marker wraps its index inside its own 512-byte region.
    for (int w = 0; w < 128; w++) begin
      d = $urandom;
      if (d == EOS) d = 32'd6;
      mem[31 * 128 + w] = d;
    end
    dur_q.delete();
    run_song(31, 130);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
